game_state_controller: RTL and testbench

- Sits between the player buttons and the dino delegate, and alongside the obstacle renderers.
- Turns raw jump/duck button levels into frame-aligned jump/duck commands for the dino delegate.
- Detects dino/obstacle pixel overlap during scan-out and runs the IDLE/RUNNING/DEAD game FSM.
- Keeps the current and high score, and issues a one-cycle world-reset pulse on every (re)start.

---
 rtl/game_pkg.sv | 16 +
 rtl/frame_edge_sampler.sv | 26 ++
 rtl/game_state_controller.sv | 148 ++++++++++++++
 tb/tb_game_state_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and score helpers for the game controller.
package game_pkg;

    localparam int SCORE_W = 16;

    localparam logic [1:0] GS_IDLE    = 2'd0;
    localparam logic [1:0] GS_RUNNING = 2'd1;
    localparam logic [1:0] GS_DEAD    = 2'd2;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/frame_edge_sampler.sv
// Samples button levels once per frame and flags rising edges against the previous frame.
module frame_edge_sampler #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [WIDTH-1:0] level_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (sample) begin
            prev <= level_in;
        end
    end

    assign level = level_in;
    assign rise  = level_in & ~prev;

endmodule

// File: rtl/game_state_controller.sv
// Game FSM: frame-aligned dino commands, collision latch, scoring and restart gating.
module game_state_controller
    import game_pkg::*;
#(
    parameter int SCORE_DIV    = 6,
    parameter int GRACE_FRAMES = 30,
    parameter int DEAD_HOLD    = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frameTick,
    input  logic        vgaActive,
    input  logic        btnJump,
    input  logic        btnDuck,
    input  logic        dinoPixel,
    input  logic        obstaclePixel,
    output logic        jump,
    output logic        duck,
    output logic [1:0]  gameState,
    output logic        isDead,
    output logic        freeze,
    output logic        worldRst,
    output logic [15:0] score,
    output logic [15:0] hiScore
);

    localparam logic [5:0] DIV_LAST   = 6'(SCORE_DIV - 1);
    localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);
    localparam logic [7:0] HOLD_INIT  = 8'(DEAD_HOLD);

    logic [1:0]         state;
    logic               hit_q;
    logic [5:0]         div_cnt;
    logic [7:0]         grace_cnt;
    logic [7:0]         hold_cnt;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] hi_q;
    logic               jump_q;
    logic               duck_q;
    logic               wr_q;

    logic jump_level;
    logic jump_edge;
    logic pix_hit;
    logic hit_now;
    logic start_game;

    frame_edge_sampler #(.WIDTH(1)) u_jump_sampler (
        .clk      (clk),
        .rst      (rst),
        .sample   (frameTick),
        .level_in (btnJump),
        .level    (jump_level),
        .rise     (jump_edge)
    );

    // A hit on the tick cycle itself still belongs to the frame being closed.
    assign pix_hit = vgaActive & dinoPixel & obstaclePixel;
    assign hit_now = hit_q | pix_hit;

    assign start_game = frameTick & jump_edge &
                        ((state == GS_IDLE) || ((state == GS_DEAD) && (hold_cnt == '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GS_IDLE;
            hit_q     <= 1'b0;
            div_cnt   <= '0;
            grace_cnt <= '0;
            hold_cnt  <= '0;
            score_q   <= '0;
            hi_q      <= '0;
            jump_q    <= 1'b0;
            duck_q    <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            wr_q <= 1'b0;

            if (frameTick) begin
                hit_q <= 1'b0;
            end else if (pix_hit) begin
                hit_q <= 1'b1;
            end

            if (start_game) begin
                state     <= GS_RUNNING;
                wr_q      <= 1'b1;
                score_q   <= '0;
                grace_cnt <= GRACE_INIT;
                div_cnt   <= '0;
                jump_q    <= 1'b0;
                duck_q    <= 1'b0;
            end else if (frameTick) begin
                case (state)
                    GS_RUNNING: begin
                        if (hit_now && (grace_cnt == '0)) begin
                            state    <= GS_DEAD;
                            jump_q   <= 1'b0;
                            duck_q   <= 1'b0;
                            hold_cnt <= HOLD_INIT;
                            if (score_q > hi_q) begin
                                hi_q <= score_q;
                            end
                        end else begin
                            jump_q <= jump_level;
                            duck_q <= btnDuck & ~jump_level;
                            if (grace_cnt != '0) begin
                                grace_cnt <= grace_cnt - 8'd1;
                            end
                            if (div_cnt == DIV_LAST) begin
                                div_cnt <= '0;
                                score_q <= sat_inc(score_q);
                            end else begin
                                div_cnt <= div_cnt + 6'd1;
                            end
                        end
                    end
                    GS_DEAD: begin
                        jump_q <= 1'b0;
                        duck_q <= 1'b0;
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    GS_IDLE: begin
                        jump_q <= 1'b0;
                        duck_q <= 1'b0;
                    end
                    default: begin
                        state  <= GS_IDLE;
                        jump_q <= 1'b0;
                        duck_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign jump      = jump_q;
    assign duck      = duck_q;
    assign gameState = state;
    assign isDead    = (state == GS_DEAD);
    assign freeze    = (state != GS_RUNNING);
    assign worldRst  = wr_q;
    assign score     = score_q;
    assign hiScore   = hi_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench: directed frames push expected post-tick outputs, a monitor checks them.
module tb_game_state_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frameTick = 1'b0;
    logic        vgaActive = 1'b0;
    logic        btnJump = 1'b0;
    logic        btnDuck = 1'b0;
    logic        dinoPixel = 1'b0;
    logic        obstaclePixel = 1'b0;
    logic        jump, duck, isDead, freeze, worldRst;
    logic [1:0]  gameState;
    logic [15:0] score, hiScore;

    logic        rst2 = 1'b1;
    logic        ft2 = 1'b0;
    logic        bj2 = 1'b0;
    logic        j2, d2, dead2, frz2, wr2;
    logic [1:0]  gs2;
    logic [15:0] sc2, hi2;

    always #5 clk = ~clk;

    game_state_controller #(.SCORE_DIV(6), .GRACE_FRAMES(30), .DEAD_HOLD(60)) dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .vgaActive(vgaActive),
        .btnJump(btnJump), .btnDuck(btnDuck), .dinoPixel(dinoPixel),
        .obstaclePixel(obstaclePixel), .jump(jump), .duck(duck),
        .gameState(gameState), .isDead(isDead), .freeze(freeze),
        .worldRst(worldRst), .score(score), .hiScore(hiScore)
    );

    // Tick every cycle with a one-frame divider reaches saturation quickly.
    game_state_controller #(.SCORE_DIV(1), .GRACE_FRAMES(0), .DEAD_HOLD(0)) dut_sat (
        .clk(clk), .rst(rst2), .frameTick(ft2), .vgaActive(1'b0),
        .btnJump(bj2), .btnDuck(1'b0), .dinoPixel(1'b0),
        .obstaclePixel(1'b0), .jump(j2), .duck(d2),
        .gameState(gs2), .isDead(dead2), .freeze(frz2),
        .worldRst(wr2), .score(sc2), .hiScore(hi2)
    );

    typedef struct {
        int          idx;
        string       name;
        logic [1:0]  gs;
        logic        jmp;
        logic        dck;
        logic        wr;
        logic [15:0] sc;
        logic [15:0] hi;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ticks_issued = 0;
    int   mon_ticks = 0;
    logic tick_d = 1'b0;
    logic done2 = 1'b0;

    always @(posedge clk) tick_d <= frameTick;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_next(input string nm, input logic [1:0] gs, input logic j,
                               input logic d, input logic w, input logic [15:0] sc,
                               input logic [15:0] hi);
        exp_t e;
        e.idx  = ticks_issued + 1;
        e.name = nm;
        e.gs   = gs;
        e.jmp  = j;
        e.dck  = d;
        e.wr   = w;
        e.sc   = sc;
        e.hi   = hi;
        sb.push_back(e);
    endtask

    task automatic frame(input logic j, input logic d, input logic ov, input logic act);
        @(negedge clk);
        btnJump = j;
        btnDuck = d;
        frameTick = 1'b1;
        ticks_issued++;
        @(negedge clk);
        frameTick = 1'b0;
        @(negedge clk);
        vgaActive = act;
        dinoPixel = ov;
        obstaclePixel = ov;
        @(negedge clk);
        vgaActive = 1'b0;
        dinoPixel = 1'b0;
        obstaclePixel = 1'b0;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [1:0]  s_gs;
        logic        s_j, s_d, s_wr, s_frz, s_dead, s_j2, s_d2, s_wr2;
        logic [15:0] s_sc, s_hi;
        forever begin
            @(negedge clk);
            if (tick_d) begin
                mon_ticks++;
                s_gs = gameState; s_j = jump; s_d = duck; s_wr = worldRst;
                s_frz = freeze; s_dead = isDead; s_sc = score; s_hi = hiScore;
                @(negedge clk);
                s_j2 = jump; s_d2 = duck; s_wr2 = worldRst;
                while (sb.size() > 0 && sb[0].idx <= mon_ticks) begin
                    e = sb.pop_front();
                    if (e.idx < mon_ticks) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL %s: checked at tick %0d, expected tick %0d", e.name, mon_ticks, e.idx);
                    end else begin
                        chk({e.name, ".gameState"}, 16'(s_gs), 16'(e.gs));
                        chk({e.name, ".jump"}, 16'(s_j), 16'(e.jmp));
                        chk({e.name, ".duck"}, 16'(s_d), 16'(e.dck));
                        chk({e.name, ".jump_held"}, 16'(s_j2), 16'(e.jmp));
                        chk({e.name, ".duck_held"}, 16'(s_d2), 16'(e.dck));
                        chk({e.name, ".worldRst"}, 16'(s_wr), 16'(e.wr));
                        chk({e.name, ".worldRst_drop"}, 16'(s_wr2), 16'd0);
                        chk({e.name, ".freeze"}, 16'(s_frz), 16'(e.gs != 2'd1));
                        chk({e.name, ".isDead"}, 16'(s_dead), 16'(e.gs == 2'd2));
                        chk({e.name, ".score"}, s_sc, e.sc);
                        chk({e.name, ".hiScore"}, s_hi, e.hi);
                    end
                end
            end
        end
    end

    initial begin : saturation
        rst2 = 1'b1;
        ft2 = 1'b0;
        bj2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        ft2 = 1'b1;
        @(posedge clk);
        repeat (65534) @(posedge clk);
        #1 chk("sat_fffe", sc2, 16'hFFFE);
        @(posedge clk);
        #1 chk("sat_ffff", sc2, 16'hFFFF);
        repeat (12) @(posedge clk);
        #1 chk("sat_hold", sc2, 16'hFFFF);
        chk("sat_state", 16'(gs2), 16'd1);
        done2 = 1'b1;
    end

    initial begin : stimulus
        logic j, d, ov, act;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        expect_next("reset_idle", 2'd0, 0, 0, 0, 16'd0, 16'd0);
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        expect_next("start", 2'd1, 0, 0, 1, 16'd0, 16'd0);
        frame(1, 0, 0, 0);

        for (int r = 1; r <= 66; r++) begin
            j   = (r == 10) || (r == 66);
            d   = (r == 10) || (r == 11) || (r == 66);
            ov  = (r == 4) || (r == 60) || (r == 65);
            act = (r != 60);
            case (r)
                5:  expect_next("grace_hit", 2'd1, 0, 0, 0, 16'd0, 16'd0);
                10: expect_next("jump_wins", 2'd1, 1, 0, 0, 16'd1, 16'd0);
                11: expect_next("duck_only", 2'd1, 0, 1, 0, 16'd1, 16'd0);
                12: expect_next("cmd_clear", 2'd1, 0, 0, 0, 16'd2, 16'd0);
                60: expect_next("score_60", 2'd1, 0, 0, 0, 16'd10, 16'd0);
                61: expect_next("inactive_overlap", 2'd1, 0, 0, 0, 16'd10, 16'd0);
                66: expect_next("death", 2'd2, 0, 0, 0, 16'd10, 16'd10);
                default: ;
            endcase
            frame(j, d, ov, act);
        end

        for (int k = 1; k <= 64; k++) begin
            j = !((k == 29) || (k == 59) || (k == 63));
            case (k)
                30: expect_next("press_in_hold", 2'd2, 0, 0, 0, 16'd10, 16'd10);
                60: expect_next("press_hold_1", 2'd2, 0, 0, 0, 16'd10, 16'd10);
                62: expect_next("held_jump", 2'd2, 0, 0, 0, 16'd10, 16'd10);
                64: expect_next("restart", 2'd1, 0, 0, 1, 16'd0, 16'd10);
                default: ;
            endcase
            frame(j, 0, 0, 0);
        end

        for (int r = 1; r <= 35; r++) begin
            if (r == 35) expect_next("pre_reset", 2'd1, 0, 0, 0, 16'd5, 16'd10);
            frame(0, 0, (r == 35), 1);
        end

        // Reset, tick and overlap all on the same cycle while grace has expired.
        expect_next("reset_priority", 2'd0, 0, 0, 0, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        frameTick = 1'b1;
        btnJump = 1'b0;
        btnDuck = 1'b0;
        vgaActive = 1'b1;
        dinoPixel = 1'b1;
        obstaclePixel = 1'b1;
        ticks_issued++;
        @(negedge clk);
        rst = 1'b0;
        frameTick = 1'b0;
        vgaActive = 1'b0;
        dinoPixel = 1'b0;
        obstaclePixel = 1'b0;
        repeat (2) @(negedge clk);
        expect_next("post_reset", 2'd0, 0, 0, 0, 16'd0, 16'd0);
        frame(0, 0, 0, 0);

        for (int i = 0; i < 70000 && !done2; i++) @(posedge clk);
        if (!done2) begin
            vectors++;
            miscompares++;
            $display("FAIL sat_timeout: got done=%0d, expected done=1", done2);
        end
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
